// File: rtl/btn_pkg.sv
// Shared definitions for the button step counter lab: FSM encoding,
// active-low 7-segment patterns and lockout counter sizing.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        WAIT_REL = 2'd2
    } state_e;

    // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_HEX [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    function automatic int lock_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex digit to active-low 7-segment decoder, shared by the
// display labs.
module seg7_hex_decoder
    import btn_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_HEX[hex_i];

endmodule

// File: rtl/btn_step_counter.sv
// Steps a modulo-MOD up/down counter once per qualified press of an
// already-debounced button, with press lockout and release qualification.
module btn_step_counter
    import btn_pkg::*;
#(
    parameter int MOD            = 10,
    parameter int LOCKOUT_CYCLES = 4
) (
    input  logic       CLKIN,
    input  logic       RESET,
    input  logic       BTN,
    input  logic       EN,
    input  logic       UP,
    output logic       PRESS,
    output logic       CARRY,
    output logic [3:0] COUNT,
    output logic [6:0] SEG
);

    localparam int                LOCK_W    = lock_width(LOCKOUT_CYCLES);
    localparam logic [3:0]        CNT_MAX   = 4'(MOD - 1);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES - 1);

    logic              s1_q;
    logic              s2_q;
    logic              prev_q;
    logic              rise;
    state_e            state_q;
    logic [LOCK_W-1:0] lock_q;
    logic [3:0]        count_q;
    logic [3:0]        count_d;
    logic              wrap;
    logic              press_q;
    logic              carry_q;

    assign rise = s2_q & ~prev_q;

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        wrap    = 1'b0;
        count_d = count_q;
        if (UP) begin
            wrap    = (count_q == CNT_MAX);
            count_d = wrap ? 4'd0 : count_q + 4'd1;
        end else begin
            wrap    = (count_q == 4'd0);
            count_d = wrap ? CNT_MAX : count_q - 4'd1;
        end
    end

    // Synchroniser flops reset high and the FSM starts in WAIT_REL, so a
    // button held through reset must be released before it can count.
    always_ff @(posedge CLKIN) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (RESET) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= WAIT_REL;
            lock_q  <= '0;
            count_q <= 4'd0;
            press_q <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            s1_q    <= BTN;
            s2_q    <= s1_q;
            prev_q  <= s2_q;
            press_q <= 1'b0;
            carry_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_q <= HOLD;
                        lock_q  <= LOCK_LOAD;
                        press_q <= 1'b1;
                        if (EN) begin
                            count_q <= count_d;
                            carry_q <= wrap;
                        end
                    end
                end
                HOLD: begin
                    if (lock_q == '0) begin
                        state_q <= WAIT_REL;
                    end else begin
                        lock_q <= lock_q - LOCK_W'(1);
                    end
                end
                WAIT_REL: begin
                    if (!s2_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= WAIT_REL;
            endcase
        end
    end

    assign PRESS = press_q;
    assign CARRY = carry_q;
    assign COUNT = count_q;

    seg7_hex_decoder u_seg (
        .hex_i (count_q),
        .seg_o (SEG)
    );

endmodule

// File: tb/tb_btn_step_counter.sv
// Directed bench for btn_step_counter (MOD = 10, LOCKOUT_CYCLES = 4).
module tb_btn_step_counter;

    logic       CLKIN;
    logic       RESET;
    logic       BTN;
    logic       EN;
    logic       UP;
    logic       PRESS;
    logic       CARRY;
    logic [3:0] COUNT;
    logic [6:0] SEG;

    int vectors     = 0;
    int miscompares = 0;
    int pulses;

    logic [6:0] seg_ref [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    btn_step_counter #(.MOD(10), .LOCKOUT_CYCLES(4)) dut (
        .CLKIN (CLKIN),
        .RESET (RESET),
        .BTN   (BTN),
        .EN    (EN),
        .UP    (UP),
        .PRESS (PRESS),
        .CARRY (CARRY),
        .COUNT (COUNT),
        .SEG   (SEG)
    );

    initial begin
        CLKIN = 1'b0;
        forever #5 CLKIN = ~CLKIN;
    end

    task automatic tick();
        @(posedge CLKIN);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Count PRESS pulses over n cycles.
    task automatic watch(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            tick();
            if (PRESS === 1'b1) cnt++;
        end
    endtask

    // One clean press: BTN high for hi cycles (hi >= 4), then low for 8.
    task automatic press(input int hi, input logic [3:0] exp_cnt, input logic exp_carry,
                         input string tag);
        BTN = 1'b1;
        tick();
        tick();
        check({tag, " press_early"}, 16'(PRESS), 16'd0);
        tick();
        check({tag, " press"}, 16'(PRESS), 16'd1);
        check({tag, " count"}, 16'(COUNT), 16'(exp_cnt));
        check({tag, " carry"}, 16'(CARRY), 16'(exp_carry));
        check({tag, " seg"}, 16'(SEG), 16'(seg_ref[exp_cnt]));
        tick();
        check({tag, " press_drop"}, 16'(PRESS), 16'd0);
        check({tag, " carry_drop"}, 16'(CARRY), 16'd0);
        repeat (hi - 4) tick();
        BTN = 1'b0;
        repeat (8) tick();
        check({tag, " count_hold"}, 16'(COUNT), 16'(exp_cnt));
    endtask

    initial begin
        RESET = 1'b1;
        BTN   = 1'b0;
        EN    = 1'b1;
        UP    = 1'b1;

        // Reset values
        tick();
        tick();
        check("rst count", 16'(COUNT), 16'd0);
        check("rst press", 16'(PRESS), 16'd0);
        check("rst carry", 16'(CARRY), 16'd0);
        check("rst seg", 16'(SEG), 16'(7'b1000000));
        RESET = 1'b0;
        watch(4, pulses);
        check("idle no press", 16'(pulses), 16'd0);

        // First press held 20 cycles: 0 -> 1
        press(20, 4'd1, 1'b0, "first");
        check("first seg1", 16'(SEG), 16'(7'b1111001));

        // Upward steps 2..9 then wrap to 0 with carry
        for (int i = 2; i <= 10; i++) begin
            press(8, 4'(i % 10), (i == 10), $sformatf("up%0d", i));
        end

        // Down wrap 0 -> 9
        UP = 1'b0;
        press(8, 4'd9, 1'b1, "down_wrap");
        check("down seg9", 16'(SEG), 16'(7'b0010000));

        // Bounce shortly after an accepted press: 9 -> 8 only once
        BTN = 1'b1;
        tick();
        tick();
        tick();
        check("bounce press", 16'(PRESS), 16'd1);
        check("bounce count", 16'(COUNT), 16'd8);
        BTN = 1'b0;
        tick();
        BTN = 1'b1;
        watch(8, pulses);
        BTN = 1'b0;
        begin
            int more;
            watch(8, more);
            pulses += more;
        end
        check("bounce extra presses", 16'(pulses), 16'd0);
        check("bounce count hold", 16'(COUNT), 16'd8);

        // Button held across a 2-cycle reset
        UP    = 1'b1;
        BTN   = 1'b1;
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        check("held rst count", 16'(COUNT), 16'd0);
        watch(10, pulses);
        check("held no press", 16'(pulses), 16'd0);
        BTN = 1'b0;
        repeat (8) tick();
        press(8, 4'd1, 1'b0, "repress");

        // Step up to 5, then a press with EN = 0
        for (int i = 2; i <= 5; i++) begin
            press(8, 4'(i), 1'b0, $sformatf("to5_%0d", i));
        end
        EN = 1'b0;
        press(8, 4'd5, 1'b0, "en0");
        EN = 1'b1;

        // Reset during HOLD, button still held
        BTN = 1'b1;
        tick();
        tick();
        tick();
        check("hold press", 16'(PRESS), 16'd1);
        check("hold count", 16'(COUNT), 16'd6);
        tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("midhold count", 16'(COUNT), 16'd0);
        check("midhold press", 16'(PRESS), 16'd0);
        check("midhold carry", 16'(CARRY), 16'd0);
        check("midhold seg", 16'(SEG), 16'(7'b1000000));
        watch(6, pulses);
        check("midhold no press", 16'(pulses), 16'd0);
        BTN = 1'b0;
        repeat (8) tick();
        press(8, 4'd1, 1'b0, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
